program_loader: RTL

//  Writer side of the instruction memory. The MIPS_DLX pipeline only reads instruction memory.

---
 rtl/program_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: writer side of instruction memory. Receives a framed program
// image from the UART byte stream, packs it into 32-bit words written from
// address 0, checks the XOR checksum and only then lets the pipeline run.
module program_loader #(
   parameter int          ADDR_W     = 10,
   parameter int          TIMEOUT    = 100000,
   parameter logic [7:0]  START_BYTE = 8'hA5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_run,
   output logic              load_done,
   output logic              load_error
);

   localparam int          TW    = $clog2(TIMEOUT + 1);
   localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

   typedef enum logic [2:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHKSUM, S_DONE, S_ERROR
   } state_t;

   state_t              r_state, w_next;
   logic [7:0]          r_cnt_hi;
   logic [15:0]         r_n;
   logic [15:0]         r_widx;
   logic [1:0]          r_bidx;
   logic [7:0]          r_acc;
   logic [31:0]         r_asm;
   logic [TW-1:0]       r_tmo;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;

   logic [15:0]         w_n;
   logic                w_active;
   logic                w_tmo_hit;
   logic                w_start;
   logic                w_last_word;

   assign w_n         = {r_cnt_hi, rx_data};
   assign w_active    = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                        (r_state == S_DATA)   || (r_state == S_CHKSUM);
   // Timeout only fires on a quiet cycle; a byte arriving on the same cycle wins.
   assign w_tmo_hit   = w_active && !rx_valid && (r_tmo == TW'(TIMEOUT));
   assign w_start     = rx_valid && (rx_data == START_BYTE);
   assign w_last_word = ((r_widx + 16'd1) == r_n);

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode and status flags (flags follow the registered state)
   always_comb begin
      w_next     = r_state;
      cpu_run    = 1'b0;
      load_done  = 1'b0;
      load_error = 1'b0;
      if (w_tmo_hit) begin
         w_next = S_ERROR;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (w_start) w_next = S_CNT_HI;
            S_CNT_HI: if (rx_valid) w_next = S_CNT_LO;
            S_CNT_LO: if (rx_valid) begin
               if ({1'b0, w_n} > DEPTH) w_next = S_ERROR;
               else if (w_n == 16'd0)   w_next = S_CHKSUM;
               else                     w_next = S_DATA;
            end
            S_DATA:   if (rx_valid && (r_bidx == 2'd3) && w_last_word) w_next = S_CHKSUM;
            S_CHKSUM: if (rx_valid) w_next = (rx_data == r_acc) ? S_DONE : S_ERROR;
            default:  w_next = S_IDLE;
         endcase
      end
      case (r_state)
         S_DONE:  begin cpu_run = 1'b1; load_done = 1'b1; end
         S_ERROR: load_error = 1'b1;
         default: ;
      endcase
   end

   // Datapath: counters, word assembly, checksum, memory write port, idle timer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt_hi <= '0;
         r_n      <= '0;
         r_widx   <= '0;
         r_bidx   <= '0;
         r_acc    <= '0;
         r_asm    <= '0;
         r_tmo    <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_we <= 1'b0;

         if (!w_active || rx_valid)   r_tmo <= '0;
         else if (r_tmo != TW'(TIMEOUT)) r_tmo <= r_tmo + TW'(1);

         if (rx_valid) begin
            case (r_state)
               S_IDLE, S_DONE, S_ERROR: if (w_start) begin
                  r_widx <= '0;
                  r_bidx <= '0;
                  r_acc  <= '0;
               end
               S_CNT_HI: r_cnt_hi <= rx_data;
               S_CNT_LO: r_n      <= w_n;
               S_DATA: begin
                  r_asm  <= {r_asm[23:0], rx_data};
                  r_acc  <= r_acc ^ rx_data;
                  r_bidx <= r_bidx + 2'd1;
                  // Word complete: write lands the cycle after its last byte
                  if (r_bidx == 2'd3) begin
                     r_we    <= 1'b1;
                     r_wdata <= {r_asm[23:0], rx_data};
                     r_addr  <= r_widx[ADDR_W-1:0];
                     r_widx  <= r_widx + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
